// File: rtl/v810_imau.sv
// rtl/v810_imau.sv - instruction-side memory access unit: ICI requests to V810 external read cycles
module v810_imau #(
   parameter bit         BUS16     = 1'b0,
   parameter logic [1:0] ST_IFETCH = 2'b00
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   input  logic [31:0] ICIA,
   output logic [31:0] ICID,
   input  logic        ICIREQ,
   output logic        ICIACK,
   output logic        BREQ,
   input  logic        BGNT,
   output logic [31:0] A,
   input  logic [31:0] D,
   output logic        BCYSTn,
   input  logic        READYn,
   output logic [3:0]  BEn,
   output logic        RW,
   output logic [1:0]  ST
);

   typedef enum logic [1:0] {IDLE, T1, T2, ACK} state_t;

   state_t      state_q;
   logic [31:0] a_q;
   logic [31:0] icid_q;
   logic        half_q;

   // Bus cycle sequencer: one read per request, two halfword reads on a 16-bit bus
   always_ff @(posedge CLK or negedge RESn) begin
      if (!RESn) begin
         state_q <= IDLE;
         a_q     <= 32'h0;
         icid_q  <= 32'h0;
         half_q  <= 1'b0;
      end else if (CE) begin
         case (state_q)
            IDLE: begin
               if (ICIREQ && BGNT) begin
                  state_q <= T1;
                  a_q     <= {ICIA[31:2], 2'b00};
                  half_q  <= 1'b0;
               end
            end
            T1: state_q <= T2;
            T2: begin
               if (!READYn) begin
                  if (!BUS16) begin
                     icid_q  <= D;
                     state_q <= ACK;
                  end else if (!half_q) begin
                     icid_q[15:0] <= D[15:0];
                     half_q       <= 1'b1;
                     a_q[1]       <= 1'b1;
                     state_q      <= T1;
                  end else begin
                     icid_q[31:16] <= D[15:0];
                     state_q       <= ACK;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes decode from state; the bus is held once a cycle has started.
   // BREQ is gated by reset so it reads low while reset is asserted.
   always_comb begin
      BCYSTn = (state_q != T1);
      ICIACK = (state_q == ACK) && ICIREQ;
      ST     = (state_q != IDLE) ? ST_IFETCH : 2'b11;
      BREQ   = RESn && ((state_q != IDLE) || ICIREQ);
   end

   assign A    = a_q;
   assign ICID = icid_q;
   assign BEn  = BUS16 ? 4'b1100 : 4'b0000;
   assign RW   = 1'b1;

endmodule

// File: tb/tb_v810_imau.sv
// tb/tb_v810_imau.sv - randomized self-checking bench for v810_imau (32-bit and 16-bit bus instances)
module tb_v810_imau;

   localparam logic [1:0] ST_IFETCH = 2'b00;

   logic        CLK = 1'b0;
   logic        RESn;
   logic        CE;

   logic [31:0] icia   [2];
   logic        req    [2];
   logic        bgnt   [2];
   logic [31:0] d      [2];
   logic        readyn [2];
   logic [31:0] icid   [2];
   logic        iciack [2];
   logic        breq   [2];
   logic [31:0] a      [2];
   logic        bcystn [2];
   logic [3:0]  ben    [2];
   logic        rw     [2];
   logic [1:0]  st     [2];

   int vectors = 0;
   int errors  = 0;

   always #5 CLK = ~CLK;

   v810_imau #(.BUS16(1'b0), .ST_IFETCH(ST_IFETCH)) u_dut0 (
      .CLK(CLK), .RESn(RESn), .CE(CE), .ICIA(icia[0]), .ICID(icid[0]),
      .ICIREQ(req[0]), .ICIACK(iciack[0]), .BREQ(breq[0]), .BGNT(bgnt[0]),
      .A(a[0]), .D(d[0]), .BCYSTn(bcystn[0]), .READYn(readyn[0]),
      .BEn(ben[0]), .RW(rw[0]), .ST(st[0])
   );

   v810_imau #(.BUS16(1'b1), .ST_IFETCH(ST_IFETCH)) u_dut1 (
      .CLK(CLK), .RESn(RESn), .CE(CE), .ICIA(icia[1]), .ICID(icid[1]),
      .ICIREQ(req[1]), .ICIACK(iciack[1]), .BREQ(breq[1]), .BGNT(bgnt[1]),
      .A(a[1]), .D(d[1]), .BCYSTn(bcystn[1]), .READYn(readyn[1]),
      .BEn(ben[1]), .RW(rw[1]), .ST(st[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_reset(input int k);
      check("rst_iciack", iciack[k], 1'b0);
      check("rst_icid", icid[k], 32'h0);
      check("rst_a", a[k], 32'h0);
      check("rst_bcystn", bcystn[k], 1'b1);
      check("rst_breq", breq[k], 1'b0);
      check("rst_st", st[k], 2'b11);
   endtask

   // One request: k selects the bus width, w0/w1 are wait states per bus cycle,
   // bdly idle cycles without grant, then optional drop/stall/mid-reset/keep-request.
   task automatic run_txn(input int k, input logic [31:0] addr, input int w0, input int w1,
                          input int bdly, input bit drop, input bit stall, input bit rstm,
                          input bit keep);
      logic [31:0] dat [2];
      logic [31:0] ea  [2];
      logic [31:0] eid;
      int nbc, lat, n, bc, idx, t2cnt, acks, ackn;
      bit pend, stalled, t2seen, done;

      dat[0] = $urandom;
      dat[1] = $urandom;
      ea[0]  = {addr[31:2], 2'b00};
      ea[1]  = ea[0] + 32'd2;
      nbc    = (k == 1) ? 2 : 1;
      lat    = (k == 1) ? 5 + w0 + w1 : 3 + w0;
      eid    = (k == 1) ? {dat[1][15:0], dat[0][15:0]} : dat[0];

      @(negedge CLK);
      req[k]    = 1'b1;
      icia[k]   = addr;
      bgnt[k]   = (bdly == 0);
      readyn[k] = 1'b1;
      for (int i = 0; i < bdly; i++) begin
         @(negedge CLK);
         check("breq_wait", breq[k], 1'b1);
         check("bcystn_wait", bcystn[k], 1'b1);
         if (i == bdly - 1) bgnt[k] = 1'b1;
      end

      n = 0; bc = -1; idx = 0; t2cnt = 0; acks = 0; ackn = -1;
      pend = 0; stalled = 0; t2seen = 0; done = 0;
      while (!done && n < lat + 3) begin
         @(negedge CLK);
         n++;
         if (iciack[k]) begin
            acks++;
            if (ackn < 0) ackn = n;
            check("icid_at_ack", icid[k], eid);
            if (keep) done = 1;
            else req[k] = 1'b0;
         end
         if (bcystn[k] == 1'b0) begin
            bc++;
            idx = (bc > 1) ? 1 : bc;
            check("a_t1", a[k], ea[idx]);
            check("st_busy", st[k], ST_IFETCH);
            pend      = 1;
            t2cnt     = 0;
            readyn[k] = 1'b1;
         end else if (pend) begin
            check("a_t2", a[k], ea[idx]);
            check("breq_busy", breq[k], 1'b1);
            bgnt[k] = 1'($urandom_range(0, 1));
            d[k]    = dat[idx];
            if (!t2seen) begin
               t2seen = 1;
               if (drop) req[k] = 1'b0;
               if (rstm) begin
                  #2 RESn = 1'b0;
                  #1 check_reset(k);
                  req[k] = 1'b0; bgnt[k] = 1'b0; readyn[k] = 1'b1;
                  @(negedge CLK);
                  RESn = 1'b1;
                  return;
               end
            end
            if (t2cnt < ((idx == 0) ? w0 : w1)) begin
               readyn[k] = 1'b1;
               t2cnt++;
            end else begin
               readyn[k] = 1'b0;
               pend      = 0;
               if (stall && !stalled) begin
                  stalled = 1;
                  CE = 1'b0;
                  repeat (5) begin
                     @(negedge CLK);
                     check("stall_a", a[k], ea[idx]);
                     check("stall_bcystn", bcystn[k], 1'b1);
                     check("stall_iciack", iciack[k], 1'b0);
                  end
                  CE = 1'b1;
               end
            end
         end
      end

      if (!keep) begin
         req[k] = 1'b0; bgnt[k] = 1'b0; readyn[k] = 1'b1;
      end
      check("bus_cycles", bc + 1, nbc);
      check("ack_count", acks, drop ? 0 : 1);
      if (!drop) check("ack_latency", ackn, lat);
      check("icid_final", icid[k], eid);
   endtask

   initial begin
      RESn = 1'b0;
      CE   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         icia[k] = 32'h0; req[k] = 1'b0; bgnt[k] = 1'b0; d[k] = 32'h0; readyn[k] = 1'b1;
      end
      repeat (2) @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         check_reset(k);
         check("ben", ben[k], (k == 1) ? 4'b1100 : 4'b0000);
         check("rw", rw[k], 1'b1);
      end
      RESn = 1'b1;

      run_txn(0, 32'h0700_1234, 0, 0, 0, 0, 0, 0, 0);
      run_txn(0, 32'h0700_1234, 4, 0, 0, 0, 0, 0, 0);
      run_txn(1, 32'hFFF0_0008, 0, 0, 0, 0, 0, 0, 0);
      run_txn(0, 32'h0000_0100, 0, 0, 0, 0, 0, 0, 1);
      run_txn(0, 32'h0000_0104, 0, 0, 0, 0, 0, 0, 0);
      run_txn(0, 32'h0000_0200, 1, 0, 3, 0, 0, 0, 0);
      run_txn(0, 32'h0000_0300, 2, 0, 0, 0, 0, 1, 0);
      run_txn(1, 32'h0000_0400, 0, 1, 0, 0, 0, 1, 0);
      run_txn(0, 32'h0000_0500, 1, 0, 0, 1, 0, 0, 0);
      run_txn(1, 32'h0000_0600, 0, 2, 0, 1, 0, 0, 0);
      run_txn(0, 32'h0000_0700, 0, 0, 0, 0, 1, 0, 0);
      run_txn(1, 32'h0000_0800, 1, 0, 1, 0, 1, 0, 0);

      for (int i = 0; i < 24; i++) begin
         run_txn(int'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
